// File: rtl/matrix_stream_reader.sv
`default_nettype none
// matrix_stream_reader: snapshots a flat matrix on start and streams the valid
// elements row-major over a valid/ready handshake with row/col tags and end markers.
module matrix_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [2:0]                       row,
  input  logic [2:0]                       col,
  input  logic [WIDTH*MAX_DIM*MAX_DIM-1:0] matrix_flat,
  input  logic                             elem_ready,
  output logic                             elem_valid,
  output logic [WIDTH-1:0]                 elem_data,
  output logic [2:0]                       elem_row,
  output logic [2:0]                       elem_col,
  output logic                             elem_eol,
  output logic                             elem_last,
  output logic                             busy,
  output logic                             done
);

  localparam int N  = MAX_DIM * MAX_DIM;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] DIM = 3'(MAX_DIM);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] snap [N];
  logic [2:0]       vr;
  logic [2:0]       vc;
  logic [2:0]       r;
  logic [2:0]       c;

  logic [2:0]    row_clamped;
  logic [2:0]    col_clamped;
  logic [IW-1:0] idx;
  logic          at_eol;
  logic          at_last;
  logic          sending;

  always_comb begin
    row_clamped = row;
    if (row == 3'd0)
      row_clamped = 3'd1;
    else if (row > DIM)
      row_clamped = DIM;
    col_clamped = col;
    if (col == 3'd0)
      col_clamped = 3'd1;
    else if (col > DIM)
      col_clamped = DIM;
  end

  assign idx     = IW'(32'(r) * MAX_DIM + 32'(c));
  assign at_eol  = (c == vc - 3'd1);
  assign at_last = at_eol && (r == vr - 3'd1);
  assign sending = (state == S_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      vr    <= 3'd0;
      vc    <= 3'd0;
      r     <= 3'd0;
      c     <= 3'd0;
      for (int k = 0; k < N; k++)
        snap[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < N; k++)
              snap[k] <= matrix_flat[k*WIDTH +: WIDTH];
            vr    <= row_clamped;
            vc    <= col_clamped;
            r     <= 3'd0;
            c     <= 3'd0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (elem_ready) begin
            // The final transfer leaves r/c parked on the last element.
            if (at_last) begin
              state <= S_DONE;
            end else if (at_eol) begin
              c <= 3'd0;
              r <= r + 3'd1;
            end else begin
              c <= c + 3'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Element fields are forced to zero whenever nothing is being presented.
  assign elem_valid = sending;
  assign elem_data  = sending ? snap[idx] : '0;
  assign elem_row   = sending ? r : 3'd0;
  assign elem_col   = sending ? c : 3'd0;
  assign elem_eol   = sending && at_eol;
  assign elem_last  = sending && at_last;
  assign busy       = sending;
  assign done       = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_reader.sv
`default_nettype none
// tb_matrix_stream_reader: directed stimulus with a scoreboard of expected
// elements, compared as the DUT hands them over.
module tb_matrix_stream_reader;

  localparam int WIDTH   = 8;
  localparam int MAX_DIM = 5;
  localparam int N       = MAX_DIM * MAX_DIM;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [2:0]           row;
  logic [2:0]           col;
  logic [WIDTH*N-1:0]   flat;
  logic                 elem_ready;
  logic                 elem_valid;
  logic [WIDTH-1:0]     elem_data;
  logic [2:0]           elem_row;
  logic [2:0]           elem_col;
  logic                 elem_eol;
  logic                 elem_last;
  logic                 busy;
  logic                 done;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  logic [15:0] sb [$];

  matrix_stream_reader #(.WIDTH(WIDTH), .MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row(row), .col(col),
    .matrix_flat(flat), .elem_ready(elem_ready), .elem_valid(elem_valid),
    .elem_data(elem_data), .elem_row(elem_row), .elem_col(elem_col),
    .elem_eol(elem_eol), .elem_last(elem_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] clamp(input logic [2:0] d);
    if (d == 3'd0) return 3'd1;
    if (d > 3'd5)  return 3'd5;
    return d;
  endfunction

  // Expected element tuple: {last, eol, row, col, data}
  task automatic push_expected(input logic [2:0] r_in, input logic [2:0] c_in);
    logic [2:0] vr, vc;
    vr = clamp(r_in);
    vc = clamp(c_in);
    for (int rr = 0; rr < int'(vr); rr++)
      for (int cc = 0; cc < int'(vc); cc++)
        sb.push_back({(rr == int'(vr) - 1) && (cc == int'(vc) - 1),
                      cc == int'(vc) - 1, 3'(rr), 3'(cc),
                      flat[(rr*MAX_DIM + cc)*WIDTH +: WIDTH]});
  endtask

  task automatic set_pattern();
    for (int k = 0; k < N; k++)
      flat[k*WIDTH +: WIDTH] = 8'(k + 1);
  endtask

  task automatic launch(input logic [2:0] r_in, input logic [2:0] c_in);
    push_expected(r_in, c_in);
    row   = r_in;
    col   = c_in;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_valid_latency", {31'd0, elem_valid}, 32'd1);
    chk("busy_in_send", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done) found = 1'b1;
    end
    chk("done_seen", {31'd0, found}, 32'd1);
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  // Monitor: scoreboard compare on transfers, stall stability, done bookkeeping.
  initial begin
    logic        held;
    logic [15:0] held_vec;
    logic [15:0] vec;
    logic [15:0] exp;
    held = 1'b0;
    held_vec = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        vec = {elem_last, elem_eol, elem_row, elem_col, elem_data};
        if (held)
          chk("stall_hold", {15'd0, elem_valid, vec}, {15'd0, 1'b1, held_vec});
        if (elem_valid && elem_ready) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp = sb.pop_front();
            chk("elem", {16'd0, vec}, {16'd0, exp});
          end
        end
        held     = elem_valid && !elem_ready;
        held_vec = vec;
        if (done) begin
          done_cnt++;
          chk("done_excl", {30'd0, busy, elem_valid}, 32'd0);
        end
      end
    end
  end

  initial begin
    int n;
    int d0;
    logic [6:0] bp;
    rst_n      = 1'b0;
    start      = 1'b0;
    row        = 3'd0;
    col        = 3'd0;
    elem_ready = 1'b1;
    set_pattern();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, elem_valid, elem_data, elem_row, elem_col,
                          elem_eol, elem_last, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {30'd0, busy, elem_valid}, 32'd0);

    // Basic 2x3 readout, ready held high
    d0 = done_cnt;
    launch(3'd2, 3'd3);
    wait_done(20, n);
    chk("basic_cycles", n, 32'd6);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("basic_done_count", done_cnt - d0, 32'd1);

    // Backpressure on 2x2: ready 1,0,0,1,0,1,1
    bp = 7'b1101001;
    launch(3'd2, 3'd2);
    for (int i = 0; i < 7; i++) begin
      elem_ready = bp[i];
      @(posedge clk); #1;
    end
    elem_ready = 1'b1;
    chk("bp_done_after_4th", {31'd0, done}, 32'd1);
    chk("bp_sb_drained", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Clamping
    launch(3'd0, 3'd7);
    wait_done(20, n);
    chk("clamp_0x7_count", n, 32'd5);
    @(posedge clk); #1;
    launch(3'd6, 3'd1);
    wait_done(20, n);
    chk("clamp_6x1_count", n, 32'd5);
    @(posedge clk); #1;

    // Snapshot and start lockout on 5x5
    d0 = done_cnt;
    launch(3'd5, 3'd5);
    repeat (4) @(posedge clk);
    #1;
    flat  = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, n);
    chk("snap_cycles", n + 5, 32'd25);
    repeat (4) @(posedge clk);
    #1;
    chk("snap_no_second", {31'd0, busy}, 32'd0);
    chk("snap_done_count", done_cnt - d0, 32'd1);
    set_pattern();

    // Asynchronous reset after the 3rd transfer of 3x3
    d0 = done_cnt;
    launch(3'd3, 3'd3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {22'd0, elem_valid, elem_data, elem_row, elem_col,
                                elem_eol, elem_last, busy, done}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_no_done", done_cnt - d0, 32'd0);
    launch(3'd3, 3'd3);
    wait_done(30, n);
    chk("post_reset_cycles", n, 32'd9);

    // Back-to-back: start during DONE is ignored, next cycle accepted
    row   = 3'd2;
    col   = 3'd2;
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_in_done_ignored", {30'd0, busy, elem_valid}, 32'd0);
    launch(3'd2, 3'd2);
    wait_done(20, n);
    chk("b2b_cycles", n, 32'd4);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/matrix_stream_reader.md
Name: matrix_stream_reader

Overview:
- Consumer end of the matrix generator interface.
- Snapshots a flat MAX_DIM×MAX_DIM element bus and its row/col dimensions on a start pulse, normally driven by the generator's update_done.
- Streams only the valid elements, in row-major order, over a valid/ready handshake with row/col tags and end markers.
- Feeds display and serial-transmit blocks downstream, so the generator can refresh while a matrix is still being read out.

Parameters:
- WIDTH, 8, bit width of one element.
- MAX_DIM, 5, maximum matrix dimension; the buffer holds MAX_DIM*MAX_DIM elements.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a readout; sampled only in IDLE.
- row  input  3  matrix row count, nominal range 1..MAX_DIM.
- col  input  3  matrix column count, nominal range 1..MAX_DIM.
- matrix_flat  input  WIDTH*MAX_DIM*MAX_DIM  element k (k = r*MAX_DIM+c) at bits [k*WIDTH +: WIDTH].
- elem_ready  input  1  downstream accepts the element this cycle.
- elem_valid  output  1  elem_data, elem_row and elem_col are valid.
- elem_data  output  WIDTH  current element.
- elem_row  output  3  row index of the current element.
- elem_col  output  3  column index of the current element.
- elem_eol  output  1  current element is the last column of its row.
- elem_last  output  1  current element is the final element of the matrix.
- busy  output  1  readout in progress.
- done  output  1  one-cycle pulse after the final element is accepted.

Behaviour:
- Reset (asynchronous, any time, including mid-readout):
  - State returns to IDLE.
  - All outputs are 0; internal counters and the snapshot buffer are cleared.
  - No partial done pulse is produced.
- Dimension clamping is applied at the start edge:
  - vr = 1 if row==0, MAX_DIM if row>MAX_DIM, else row.
  - vc is clamped the same way from col.
- States:
  - IDLE: busy=0, elem_valid=0.
  - SEND: busy=1, elem_valid=1.
  - DONE: one cycle, done=1, busy=0, then IDLE.
- IDLE → SEND on a clk edge with start=1:
  - matrix_flat, vr and vc are captured into internal registers.
  - r and c are set to 0.
  - On the next cycle elem_valid=1 and element (0,0) is presented. Latency from start edge to first valid is 1 cycle.
- start is ignored in SEND and in DONE.
- Changes on matrix_flat, row or col after the capture edge have no effect on the readout in progress.
- SEND, holding an element:
  - Output fields: elem_data=snapshot[r*MAX_DIM+c], elem_row=r, elem_col=c, elem_eol=(c==vc-1), elem_last=(r==vr-1 && c==vc-1).
  - Transfer occurs on an edge where elem_valid && elem_ready.
  - Without a transfer, all elem_* outputs hold stable.
  - On a transfer that is not the last element: if c==vc-1, then c←0 and r←r+1; else c←c+1.
  - elem_valid stays 1, giving back-to-back throughput of 1 element/cycle.
  - Positions with c≥vc or r≥vr are never emitted.
- Transfer of the element with elem_last=1: next state is DONE with elem_valid=0, elem_last=0, done=1 for exactly one cycle.
- start=1 during the DONE cycle is ignored. It is accepted from the following IDLE cycle onward.
- Element count per readout is exactly vr*vc, minimum 1 and maximum MAX_DIM².
- Index arithmetic:
  - r and c are 3-bit.
  - The flat index is 5-bit, valid for MAX_DIM≤5.
  - Index arithmetic never wraps past vr*vc-1.
- elem_ready held 0 indefinitely stalls SEND with no timeout.

Test Plan:
- Basic 2×3 readout:
  - Stimulus: matrix_flat element k = k+1, row=2, col=3, elem_ready=1, one-cycle start.
  - Required response: elem_valid rises 1 cycle after start and stays high for 6 consecutive cycles.
  - elem_data sequence 1,2,3,6,7,8; elem_eol on the 3rd and 6th elements; elem_last on the 6th only.
  - done pulses 1 cycle after the 6th element, lasting 1 cycle; busy falls with it.
- Backpressure on a 2×2 readout:
  - Stimulus: elem_ready toggles 1,0,0,1,0,1,1.
  - Required response: each element is held stable through the ready=0 cycles.
  - Sequence 1,2,6,7 with no duplicates or drops; done follows the 4th transfer.
- Clamping:
  - row=0, col=7 → exactly 5 elements, data 1..5, elem_row always 0, elem_last on elem_col=4.
  - row=6, col=1 → 5 elements, data 1,6,11,16,21.
- Snapshot and start lockout during a 5×5 readout:
  - Stimulus: change matrix_flat to all-0xFF and pulse start mid-readout.
  - Required response: all 25 original values 1..25 are emitted, there is only one done pulse, and no second readout occurs.
- Reset mid-operation:
  - Stimulus: assert rst_n low after the 3rd transfer of a 3×3 readout.
  - Required response: all outputs are 0 immediately (asynchronous) and there is no done pulse.
  - A new start after reset release reads out from (0,0).
- Back-to-back readouts:
  - Stimulus: start asserted during the DONE cycle and again on the cycle after DONE.
  - Required response: the first start is ignored; the second launches a new readout with elem_valid 1 cycle later.
